cpu_boot_loader: RTL and testbench
==================================

// Module: cpu_boot_loader
// PURPOSE
//  Boot sequencer for the RV32I pipeline core: holds the core in reset, receives a program
//  image over a byte stream, writes it word-by-word into instruction memory, verifies a
//  checksum, then releases the core. It is the only imem writer; the core only reads imem.
// PARAMETERS
//  IMEM_WORDS  1024   instruction memory depth in 32-bit words (power of two)
//  MAGIC       8'hA5  start-of-image byte
//  AW          $clog2(IMEM_WORDS)  word-address width (derived, not overridden)
// PORTS
//  clk          in   1     clock
//  reset        in   1     synchronous, active-high
//  boot_req     in   1     pulse: abort or finish current activity and reload
//  rx_valid     in   1     byte-stream valid
//  rx_data      in   8     byte-stream data
//  rx_ready     out  1     byte-stream ready; a byte transfers when rx_valid & rx_ready
//  imem_we      out  1     imem write strobe (full word)
//  imem_addr    out  AW    imem word address
//  imem_wdata   out  32    imem write data
//  cpu_reset    out  1     to core reset (core samples it synchronously)
//  busy         out  1     image load in progress (LEN/DATA/CSUM)
//  done         out  1     image accepted, core running
//  err          out  1     load failed
//  err_cause    out  2     01 length overflow, 10 checksum mismatch, 00 none
//  words_loaded out  AW+1  words written to imem during the current or last load
// BEHAVIOUR
//  - Reset values: state=WAIT_MAGIC, cpu_reset=1, imem_we=0, imem_addr=0, imem_wdata=0,
//    busy=0, done=0, err=0, err_cause=0, words_loaded=0; rx_ready=1 one cycle after reset.
//  - Image format: MAGIC, LEN[7:0..31:24] (word count, little-endian), 4*LEN payload bytes,
//    CSUM = sum of all payload bytes mod 256.
//  - States: WAIT_MAGIC -> LEN (on MAGIC) -> DATA (after 4th LEN byte, LEN!=0) -> CSUM -> RUN.
//    LEN==0 goes directly LEN->CSUM (expected CSUM 8'h00). Any byte other than MAGIC is
//    dropped in WAIT_MAGIC.
//  - LEN > IMEM_WORDS: ERROR with err_cause=01 the cycle after the 4th LEN byte; no writes.
//  - DATA: bytes assembled little-endian (first byte -> [7:0]). When the 4th byte of a word
//    transfers, the next cycle drives imem_we=1 for exactly one cycle with
//    imem_addr=word index (0..LEN-1) and the assembled word; words_loaded increments then.
//  - CSUM: match -> RUN; cpu_reset falls the cycle after the CSUM byte transfers (last imem
//    write always precedes it). Mismatch -> ERROR, err_cause=10, cpu_reset stays 1.
//  - rx_ready=1 in WAIT_MAGIC, LEN, DATA, CSUM, ERROR; 0 in RUN. One byte per cycle max;
//    rx_valid gaps are tolerated in any state with no timeout.
//  - ERROR: cpu_reset=1, err held; MAGIC byte restarts at LEN (clears err, err_cause,
//    words_loaded); other bytes dropped.
//  - boot_req (any state): rx_ready forced 0 that cycle; next cycle state=WAIT_MAGIC,
//    cpu_reset=1, done/err/busy cleared, words_loaded=0, partial word discarded.
//    boot_req has priority over a simultaneous byte.
//  - busy=1 in LEN/DATA/CSUM; done=1 only in RUN; all status outputs registered.
//  - Payload/length counters are 32-bit internally; no wrap since LEN<=IMEM_WORDS is enforced.
// TESTING
//  1. A5,02,00,00,00, 13 00 00 00, 6F 00 00 00, 82 -> writes addr0=0x00000013, addr1=0x0000006F;
//     cpu_reset 1->0 one cycle after CSUM byte; done=1, words_loaded=2.
//  2. Same image with CSUM 0x83 -> err=1, err_cause=10, cpu_reset stays 1; then a valid image
//     recovers to done=1.
//  3. IMEM_WORDS=1024, LEN=0x00000401 -> err_cause=01 after 4th LEN byte, imem_we never set.
//  4. Garbage 00 FF 5A before A5, rx_valid toggled every other cycle -> garbage ignored,
//     image from test 1 loads identically.
//  5. boot_req during DATA (after 5 payload bytes) -> no further writes, cpu_reset=1,
//     words_loaded=0; subsequent full image loads.
//  6. LEN=0, CSUM=00 -> RUN with no imem writes; reset asserted in RUN -> all outputs to reset values.

Source files
------------

// File: rtl/cpu_boot_loader.sv
// Boot sequencer: holds the core in reset, loads a MAGIC/LEN/payload/CSUM byte stream
// into instruction memory word by word, verifies the checksum, then releases the core.
module cpu_boot_loader #(
   parameter int          IMEM_WORDS = 1024,
   parameter logic [7:0]  MAGIC      = 8'hA5,
   localparam int         AW         = $clog2(IMEM_WORDS)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          boot_req,
   input  logic          rx_valid,
   input  logic [7:0]    rx_data,
   output logic          rx_ready,
   output logic          imem_we,
   output logic [AW-1:0] imem_addr,
   output logic [31:0]   imem_wdata,
   output logic          cpu_reset,
   output logic          busy,
   output logic          done,
   output logic          err,
   output logic [1:0]    err_cause,
   output logic [AW:0]   words_loaded
);

   // Handshake: a byte moves on a rising clk edge where rx_valid && rx_ready are both 1;
   // rx_ready never depends on rx_valid.
   typedef enum logic [2:0] {
      S_WAIT_MAGIC, S_LEN, S_DATA, S_CSUM, S_RUN, S_ERROR
   } state_t;

   state_t        state, state_d;
   logic          ready_en;
   logic          xfer;
   logic [1:0]    byte_cnt;
   logic [31:0]   len_q;
   logic [31:0]   len_full;
   logic [31:0]   word_idx;
   logic [23:0]   word_acc;
   logic [7:0]    sum_q;
   logic          cpu_reset_d, busy_d, done_d, err_d;
   logic [1:0]    err_cause_d;

   assign rx_ready = ready_en && !boot_req && (state != S_RUN);
   assign xfer     = rx_valid && rx_ready;
   assign len_full = {rx_data, len_q[31:8]};

   // State register
   always_ff @(posedge clk) begin
      if (reset) state <= S_WAIT_MAGIC;
      else       state <= state_d;
   end

   // Next-state logic; boot_req wins over any byte in the same cycle
   always_comb begin
      state_d = state;
      if (boot_req) begin
         state_d = S_WAIT_MAGIC;
      end else if (xfer) begin
         case (state)
            S_WAIT_MAGIC, S_ERROR: if (rx_data == MAGIC) state_d = S_LEN;
            S_LEN: begin
               if (byte_cnt == 2'd3) begin
                  if (len_full > 32'(IMEM_WORDS)) state_d = S_ERROR;
                  else if (len_full == 32'd0)     state_d = S_CSUM;
                  else                            state_d = S_DATA;
               end
            end
            S_DATA: if (byte_cnt == 2'd3 && (word_idx + 32'd1) == len_q) state_d = S_CSUM;
            S_CSUM: state_d = (rx_data == sum_q) ? S_RUN : S_ERROR;
            default: state_d = state;
         endcase
      end
   end

   // Status outputs decoded from the next state, then registered below
   always_comb begin
      cpu_reset_d = (state_d != S_RUN);
      done_d      = (state_d == S_RUN);
      busy_d      = (state_d == S_LEN) || (state_d == S_DATA) || (state_d == S_CSUM);
      err_d       = (state_d == S_ERROR);
      err_cause_d = 2'b00;
      if (state_d == S_ERROR) begin
         if (state == S_LEN)       err_cause_d = 2'b01;
         else if (state == S_CSUM) err_cause_d = 2'b10;
         else                      err_cause_d = err_cause;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         ready_en  <= 1'b0;
         cpu_reset <= 1'b1;
         done      <= 1'b0;
         busy      <= 1'b0;
         err       <= 1'b0;
         err_cause <= 2'b00;
      end else begin
         ready_en  <= 1'b1;
         cpu_reset <= cpu_reset_d;
         done      <= done_d;
         busy      <= busy_d;
         err       <= err_d;
         err_cause <= err_cause_d;
      end
   end

   // Length/payload datapath and the imem write port
   always_ff @(posedge clk) begin
      if (reset) begin
         imem_we      <= 1'b0;
         imem_addr    <= '0;
         imem_wdata   <= '0;
         words_loaded <= '0;
         byte_cnt     <= 2'd0;
         len_q        <= '0;
         word_idx     <= '0;
         word_acc     <= '0;
         sum_q        <= '0;
      end else begin
         imem_we <= 1'b0;
         if (boot_req) begin
            byte_cnt     <= 2'd0;
            words_loaded <= '0;
         end else if (xfer) begin
            case (state)
               S_WAIT_MAGIC, S_ERROR: begin
                  if (rx_data == MAGIC) begin
                     byte_cnt     <= 2'd0;
                     len_q        <= '0;
                     word_idx     <= '0;
                     sum_q        <= '0;
                     words_loaded <= '0;
                  end
               end
               S_LEN: begin
                  len_q    <= len_full;
                  byte_cnt <= byte_cnt + 2'd1;
               end
               S_DATA: begin
                  sum_q    <= sum_q + rx_data;
                  byte_cnt <= byte_cnt + 2'd1;
                  word_acc <= {rx_data, word_acc[23:8]};
                  if (byte_cnt == 2'd3) begin
                     imem_we      <= 1'b1;
                     imem_addr    <= word_idx[AW-1:0];
                     imem_wdata   <= {rx_data, word_acc};
                     word_idx     <= word_idx + 32'd1;
                     words_loaded <= words_loaded + {{AW{1'b0}}, 1'b1};
                  end
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_cpu_boot_loader.sv
// Bench for cpu_boot_loader: table of whole-image loads plus hand-written sequences for
// checksum timing, boot_req abort and reset-in-RUN; imem writes are checked by a scoreboard.
module tb_cpu_boot_loader;
   localparam int AW = 10;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          boot_req = 1'b0;
   logic          rx_valid = 1'b0;
   logic [7:0]    rx_data = 8'h00;
   logic          rx_ready;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wdata;
   logic          cpu_reset, busy, done, err;
   logic [1:0]    err_cause;
   logic [AW:0]   words_loaded;

   int n_pass  = 0;
   int n_total = 0;
   logic [AW+31:0] exp_q[$];

   cpu_boot_loader dut (
      .clk(clk), .reset(reset), .boot_req(boot_req),
      .rx_valid(rx_valid), .rx_data(rx_data), .rx_ready(rx_ready),
      .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
      .cpu_reset(cpu_reset), .busy(busy), .done(done), .err(err),
      .err_cause(err_cause), .words_loaded(words_loaded)
   );

   // Clock / reset
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   // Scoreboard: every imem write must match the head of the expected queue
   always @(negedge clk) begin
      if (!reset && imem_we) begin
         if (exp_q.size() == 0) begin
            check("unexpected_write", {22'd0, imem_addr}, 32'hFFFFFFFF);
         end else begin
            logic [AW+31:0] e;
            e = exp_q.pop_front();
            check("imem_addr", {22'd0, imem_addr}, {22'd0, e[AW+31:32]});
            check("imem_wdata", imem_wdata, e[31:0]);
         end
      end
   end

   // Driver tasks (entered and left 1 time unit after a rising edge)
   task automatic send_byte(input logic [7:0] b, input bit gap);
      int n;
      n = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      @(negedge clk);
      while (!rx_ready && n < 50) begin
         n++;
         @(negedge clk);
      end
      if (!rx_ready) check("rx_ready_timeout", 32'd0, 32'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      if (gap) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic pulse_boot_req();
      boot_req = 1'b1;
      @(posedge clk); #1;
      boot_req = 1'b0;
   endtask

   task automatic send_image(input logic [31:0] len, input logic [31:0] w0, input logic [31:0] w1,
                             input logic [7:0] bad, input bit gap);
      logic [7:0]  sum;
      logic [31:0] word;
      logic [7:0]  b;
      sum = 8'h00;
      send_byte(8'hA5, gap);
      for (int k = 0; k < 4; k++) send_byte(len[8*k +: 8], gap);
      if (len <= 32'd1024) begin
         for (int w = 0; w < int'(len); w++) begin
            if (len <= 32'd2) word = (w == 0) ? w0 : w1;
            else              word = $urandom;
            for (int k = 0; k < 4; k++) begin
               b = word[8*k +: 8];
               sum = sum + b;
               if (k == 3) exp_q.push_back({w[AW-1:0], word});
               send_byte(b, gap);
            end
         end
         send_byte(sum + bad, gap);
      end
   endtask

   typedef struct {
      logic [31:0] len;
      logic [31:0] w0;
      logic [31:0] w1;
      logic [7:0]  bad;
      bit          gap;
      bit          garbage;
      bit          pre_boot;
      logic        exp_done;
      logic        exp_err;
      logic [1:0]  exp_cause;
      logic [10:0] exp_words;
   } vec_t;

   vec_t vecs[9];

   initial begin
      vecs[0] = '{32'd2,     32'h13, 32'h6F, 8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'd2};
      vecs[1] = '{32'd2,     32'h13, 32'h6F, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 11'd2};
      vecs[2] = '{32'd2,     32'h13, 32'h6F, 8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 11'd2};
      vecs[3] = '{32'h401,   32'h0,  32'h0,  8'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 2'b01, 11'd0};
      vecs[4] = '{32'd2,     32'h13, 32'h6F, 8'd0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 11'd2};
      vecs[5] = '{32'd0,     32'h0,  32'h0,  8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'd0};
      vecs[6] = '{32'd1024,  32'h0,  32'h0,  8'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 11'd1024};
      vecs[7] = '{32'd3,     32'h0,  32'h0,  8'd7, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 11'd3};
      vecs[8] = '{32'd1,     32'h0,  32'h0,  8'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00, 11'd1};

      // Reset values
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check("rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("rst_imem_we", {31'd0, imem_we}, 32'd0);
      check("rst_imem_addr", {22'd0, imem_addr}, 32'd0);
      check("rst_imem_wdata", imem_wdata, 32'd0);
      check("rst_status", {28'd0, busy, done, err, 1'b0}, 32'd0);
      check("rst_err_cause", {30'd0, err_cause}, 32'd0);
      check("rst_words", {21'd0, words_loaded}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("rx_ready_after_reset", {31'd0, rx_ready}, 32'd1);

      // Reference image; cpu_reset must fall exactly one cycle after the CSUM byte
      begin
         logic [7:0] img[13];
         img = '{8'hA5, 8'h02, 8'h00, 8'h00, 8'h00, 8'h13, 8'h00, 8'h00, 8'h00,
                 8'h6F, 8'h00, 8'h00, 8'h00};
         exp_q.push_back({10'd0, 32'h00000013});
         exp_q.push_back({10'd1, 32'h0000006F});
         for (int i = 0; i < 13; i++) send_byte(img[i], 1'b0);
         check("busy_in_csum", {31'd0, busy}, 32'd1);
         check("cpu_reset_before_csum", {31'd0, cpu_reset}, 32'd1);
         send_byte(8'h82, 1'b0);
         check("cpu_reset_after_csum", {31'd0, cpu_reset}, 32'd0);
         check("done_t1", {31'd0, done}, 32'd1);
         check("words_t1", {21'd0, words_loaded}, 32'd2);
         check("rx_ready_run", {31'd0, rx_ready}, 32'd0);
         check("queue_drained_t1", exp_q.size(), 32'd0);
      end

      // boot_req in the middle of DATA, with a byte offered in the same cycle
      pulse_boot_req();
      send_byte(8'hA5, 1'b0);
      send_byte(8'h02, 1'b0);
      for (int k = 0; k < 3; k++) send_byte(8'h00, 1'b0);
      exp_q.push_back({10'd0, 32'hDEADBEEF});
      send_byte(8'hEF, 1'b0); send_byte(8'hBE, 1'b0);
      send_byte(8'hAD, 1'b0); send_byte(8'hDE, 1'b0);
      send_byte(8'h11, 1'b0);
      @(negedge clk);
      check("busy_data", {31'd0, busy}, 32'd1);
      check("words_mid", {21'd0, words_loaded}, 32'd1);
      @(posedge clk); #1;
      boot_req = 1'b1; rx_valid = 1'b1; rx_data = 8'h22;
      @(negedge clk);
      check("rx_ready_boot_req", {31'd0, rx_ready}, 32'd0);
      @(posedge clk); #1;
      boot_req = 1'b0; rx_valid = 1'b0;
      check("abort_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("abort_words", {21'd0, words_loaded}, 32'd0);
      check("abort_status", {29'd0, busy, done, err}, 32'd0);
      repeat (6) @(posedge clk);
      #1;

      // LEN=0 image, then reset while running
      send_image(32'd0, 32'h0, 32'h0, 8'd0, 1'b0);
      check("len0_done", {31'd0, done}, 32'd1);
      check("len0_words", {21'd0, words_loaded}, 32'd0);
      reset = 1'b1;
      @(posedge clk); #1;
      check("run_rst_cpu_reset", {31'd0, cpu_reset}, 32'd1);
      check("run_rst_status", {27'd0, busy, done, err, err_cause}, 32'd0);
      check("run_rst_words", {21'd0, words_loaded}, 32'd0);
      check("run_rst_rx_ready", {31'd0, rx_ready}, 32'd0);
      reset = 1'b0;
      @(posedge clk); #1;
      check("run_rst_rx_ready_after", {31'd0, rx_ready}, 32'd1);

      // Table-driven image loads
      for (int i = 0; i < 9; i++) begin
         if (vecs[i].pre_boot) pulse_boot_req();
         if (vecs[i].garbage) begin
            send_byte(8'h00, 1'b1); send_byte(8'hFF, 1'b1); send_byte(8'h5A, 1'b1);
         end
         send_image(vecs[i].len, vecs[i].w0, vecs[i].w1, vecs[i].bad, vecs[i].gap);
         @(negedge clk);
         check($sformatf("v%0d_done", i), {31'd0, done}, {31'd0, vecs[i].exp_done});
         check($sformatf("v%0d_err", i), {31'd0, err}, {31'd0, vecs[i].exp_err});
         check($sformatf("v%0d_cause", i), {30'd0, err_cause}, {30'd0, vecs[i].exp_cause});
         check($sformatf("v%0d_words", i), {21'd0, words_loaded}, {21'd0, vecs[i].exp_words});
         check($sformatf("v%0d_cpu_reset", i), {31'd0, cpu_reset}, {31'd0, ~vecs[i].exp_done});
         check($sformatf("v%0d_busy", i), {31'd0, busy}, 32'd0);
         check($sformatf("v%0d_queue", i), exp_q.size(), 32'd0);
         @(posedge clk); #1;
      end

      repeat (4) @(posedge clk);
      check("final_queue_empty", exp_q.size(), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
